// File: rtl/score_disp_pkg.sv
// -----------------------------------------------------------------------------
// score_disp_pkg
// Shared geometry and pixel helpers for the scrolling score display.
//   - Matrix/strip/glyph geometry constants.
//   - snapshot_t : the four latched 15-bit digit glyphs (thousands first).
//   - glyph_bit  : bit position of glyph pixel (gr, gc) inside a 15-bit glyph.
//   - strip_index: strip column shown at window column c for a given offset.
//   - strip_pixel: pixel value of strip column s on glyph row gr.
// -----------------------------------------------------------------------------
package score_disp_pkg;

    localparam int STRIP_LEN     = 24;
    localparam int GLYPH_W       = 3;
    localparam int GLYPH_H       = 5;
    localparam int GLYPH_TOP_ROW = 1;
    localparam int MATRIX_N      = 8;
    localparam int DIGIT_PITCH   = GLYPH_W + 1;  // glyph plus one blank spacer column
    localparam int NUM_DIGITS    = 4;

    typedef logic [14:0] glyph_t;

    typedef struct packed {
        glyph_t d3;  // thousands
        glyph_t d2;  // hundreds
        glyph_t d1;  // tens
        glyph_t d0;  // ones
    } snapshot_t;

    // Row-major glyph layout with the top-left pixel in the MSB.
    function automatic int glyph_bit(input int gr, input int gc);
        return 14 - (gr * GLYPH_W + gc);
    endfunction

    // Window column c shows strip column (offset + c) mod STRIP_LEN.
    // offset <= 23 and c <= 7, so a single conditional subtract suffices.
    function automatic int strip_index(input logic [4:0] offset, input int c);
        int sum;
        sum = int'(offset) + c;
        if (sum >= STRIP_LEN) sum = sum - STRIP_LEN;
        return sum;
    endfunction

    // Strip layout: four digits at a pitch of 4 columns (3 glyph + 1 blank),
    // followed by blank padding up to STRIP_LEN.
    function automatic logic strip_pixel(input snapshot_t snap, input int s, input int gr);
        int     slot;
        int     gc;
        glyph_t g;
        slot = s / DIGIT_PITCH;
        gc   = s % DIGIT_PITCH;
        if (slot >= NUM_DIGITS || gc >= GLYPH_W) return 1'b0;
        case (slot)
            0:       g = snap.d3;
            1:       g = snap.d2;
            2:       g = snap.d1;
            default: g = snap.d0;
        endcase
        return g[4'(glyph_bit(gr, gc))];
    endfunction

endpackage

// File: rtl/score_matrix_scroller_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running 0..DIV-1 counter that advances only while en=1 and emits a
// combinational one-cycle tick on the cycle it sits at its terminal count.
//   clk   : system clock
//   rst_n : synchronous active-low reset (counter to 0)
//   en    : count enable; the count holds while low
//   tick  : high while en=1 and count == DIV-1 (the count wraps on that edge)
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int           W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TERM = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = en && (cnt_q == TERM);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample their _d values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/score_matrix_scroller.sv
// -----------------------------------------------------------------------------
// score_matrix_scroller
// Drives a row-multiplexed 8x8 LED matrix, scrolling a four-digit score
// (3x5 glyphs) leftward through an 8-column window over a 24-column strip.
// The glyphs are snapshotted once per scroll pass so a score change never
// tears mid-scroll.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   en         : display enable; low freezes scan/scroll and blanks outputs
//   sco3..sco0 : glyphs of thousands..ones digit
//   row        : one-hot row select, row[0] = top row (registered)
//   col        : column data, col[7] = leftmost column (registered)
//   pass_done  : one-cycle pulse after the offset wraps 23 -> 0
// -----------------------------------------------------------------------------
module score_matrix_scroller
    import score_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 12500,
    parameter int unsigned SCROLL_DIV = 15000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [14:0] sco3,
    input  logic [14:0] sco2,
    input  logic [14:0] sco1,
    input  logic [14:0] sco0,
    output logic [7:0]  row,
    output logic [7:0]  col,
    output logic        pass_done
);

    logic scan_tick;
    logic scroll_tick;
    logic wrap;

    logic [2:0] r_q,            r_d;
    logic [4:0] offset_q,       offset_d;
    snapshot_t  snap_q,         snap_d;
    logic       load_pending_q, load_pending_d;
    logic [7:0] row_q,          row_d;
    logic [7:0] col_q,          col_d;
    logic       pass_done_q,    pass_done_d;

    tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (scan_tick)
    );

    tick_divider #(.DIV(SCROLL_DIV)) u_scroll_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (scroll_tick)
    );

    assign wrap = scroll_tick && (offset_q == 5'(STRIP_LEN - 1));

    // Position and snapshot update. Ticks already imply en=1, so r and offset
    // hold automatically while the display is disabled.
    always_comb begin
        r_d            = r_q;
        offset_d       = offset_q;
        snap_d         = snap_q;
        load_pending_d = load_pending_q;
        pass_done_d    = wrap;

        if (scan_tick)   r_d      = r_q + 3'd1;  // 7 wraps to 0 naturally
        if (scroll_tick) offset_d = wrap ? 5'd0 : offset_q + 5'd1;

        // The first enabled cycle after reset and every pass wrap reload the
        // glyphs; pass_done is only pulsed for the wrap case.
        if (en) begin
            if (load_pending_q || wrap) snap_d = {sco3, sco2, sco1, sco0};
            load_pending_d = 1'b0;
        end
    end

    // Output image is computed from the current registered r/offset/snapshot,
    // so row and col always change together one cycle after any of them.
    always_comb begin
        row_d = '0;
        col_d = '0;
        if (en) begin
            row_d = 8'b1 << r_q;
            if (int'(r_q) >= GLYPH_TOP_ROW && int'(r_q) < GLYPH_TOP_ROW + GLYPH_H) begin
                for (int c = 0; c < MATRIX_N; c++) begin
                    col_d[MATRIX_N-1-c] = strip_pixel(snap_q, strip_index(offset_q, c),
                                                      int'(r_q) - GLYPH_TOP_ROW);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q            <= '0;
            offset_q       <= '0;
            snap_q         <= '0;
            load_pending_q <= 1'b1;
            row_q          <= '0;
            col_q          <= '0;
            pass_done_q    <= 1'b0;
        end else begin
            r_q            <= r_d;
            offset_q       <= offset_d;
            snap_q         <= snap_d;
            load_pending_q <= load_pending_d;
            row_q          <= row_d;
            col_q          <= col_d;
            pass_done_q    <= pass_done_d;
        end
    end

    assign row       = row_q;
    assign col       = col_q;
    assign pass_done = pass_done_q;

endmodule

// File: tb/tb_score_matrix_scroller.sv
// -----------------------------------------------------------------------------
// tb_score_matrix_scroller
// Self-checking bench for score_matrix_scroller with SCAN_DIV=2, SCROLL_DIV=32.
// The reference model counts enabled cycles since reset and derives row index,
// scroll offset and pass boundaries from that count with plain division.
// -----------------------------------------------------------------------------
module tb_score_matrix_scroller;

    localparam int SCAN_DIV   = 2;
    localparam int SCROLL_DIV = 32;
    localparam int STRIP      = 24;
    localparam int WAIT_MAX   = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [14:0] sco3, sco2, sco1, sco0;
    logic [7:0]  row, col;
    logic        pass_done;

    int checks = 0;
    int errors = 0;

    score_matrix_scroller #(
        .SCAN_DIV   (SCAN_DIV),
        .SCROLL_DIV (SCROLL_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sco3      (sco3),
        .sco2      (sco2),
        .sco1      (sco1),
        .sco0      (sco0),
        .row       (row),
        .col       (col),
        .pass_done (pass_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          n;          // enabled cycles since reset
    bit          lp;         // initial load still pending
    logic [14:0] snap [4];   // index 0 = thousands
    logic [7:0]  exp_row, exp_col;
    logic        exp_pd;
    int          mr, moff;   // r/offset that the current expected outputs show
    bit          seen_rst = 0;

    // Strip column s: digits at columns 0-2, 4-6, 8-10, 12-14, all else blank.
    function automatic logic [7:0] model_col(input int r, input int off);
        logic [7:0] v;
        logic [14:0] g;
        int s;
        v = '0;
        if (r >= 1 && r <= 5) begin
            for (int c = 0; c < 8; c++) begin
                s = (off + c) % STRIP;
                if (s < 15 && (s % 4) != 3) begin
                    g = snap[s / 4];
                    v[7 - c] = g[14 - ((r - 1) * 3 + (s % 4))];
                end
            end
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0; lp = 1;
            for (int i = 0; i < 4; i++) snap[i] = '0;
            exp_row = '0; exp_col = '0; exp_pd = 1'b0;
            seen_rst = 1;
        end else if (en) begin
            mr      = (n / SCAN_DIV) % 8;
            moff    = (n / SCROLL_DIV) % STRIP;
            exp_row = 8'(1 << mr);
            exp_col = model_col(mr, moff);
            exp_pd  = ((n + 1) % (SCROLL_DIV * STRIP)) == 0;
            if (lp || exp_pd) begin
                snap[0] = sco3; snap[1] = sco2; snap[2] = sco1; snap[3] = sco0;
            end
            lp = 0;
            n++;
        end else begin
            exp_row = '0; exp_col = '0; exp_pd = 1'b0;
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (seen_rst) begin
            check("row", 32'(row), 32'(exp_row));
            check("col", 32'(col), 32'(exp_col));
            check("pass_done", 32'(pass_done), 32'(exp_pd));
        end
    end

    // Waits for the negedge where the outputs show row index r and offset off
    // (negative = don't care). An expired bound is counted as a failure.
    task automatic wait_state(input int r, input int off);
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            if (exp_row != 0 && (r < 0 || mr == r) && (off < 0 || moff == off)) return;
        end
        checks++; errors++;
        $display("FAIL wait_state timeout: r=%0d off=%0d not reached", r, off);
    endtask

    task automatic set_sco(input logic [14:0] a, b, c, d);
        sco3 = a; sco2 = b; sco1 = c; sco0 = d;
    endtask

    logic [7:0] row_tbl [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] col_tbl [9] = '{8'h00, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'h00, 8'h00, 8'h00};

    initial begin
        int hold;
        bit got_pd;

        rst_n = 1'b0; en = 1'b0;
        set_sco(15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF);
        repeat (3) @(negedge clk);
        check("reset row", 32'(row), 32'h0);
        check("reset col", 32'(col), 32'h0);
        check("reset pass_done", 32'(pass_done), 32'h0);

        // All-ones glyphs at offset 0: row scan order and column image.
        rst_n = 1'b1; en = 1'b1;
        wait_state(0, 0);
        for (int i = 0; i < 9; i++) begin
            check("scan row", 32'(row), 32'(row_tbl[i]));
            check("scan col", 32'(col), 32'(col_tbl[i]));
            if (i < 8) repeat (2) @(negedge clk);
        end
        wait_state(1, 1);
        check("offset1 col", 32'(col), 32'hDD);

        // Change glyphs mid-pass: old image persists until the wrap.
        wait_state(-1, 5);
        set_sco(15'h7FFF, 15'h0000, 15'h0000, 15'h0000);
        wait_state(1, 10);
        check("no tear col", 32'(col), 32'hB8);
        got_pd = 0;
        for (int i = 0; i < 1000 && !got_pd; i++) begin
            @(negedge clk);
            if (pass_done) got_pd = 1;
        end
        check("pass_done seen", 32'(got_pd), 32'h1);
        wait_state(1, 20);
        check("offset20 col", 32'(col), 32'h0E);

        // Disable for 50 cycles mid-pass: outputs blank, position frozen.
        wait_state(-1, 7);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("en0 row", 32'(row), 32'h0);
            check("en0 col", 32'(col), 32'h0);
        end
        en = 1'b1;
        repeat (4) @(negedge clk);

        // Reset at offset 13 with a different score pending; reload after reset.
        wait_state(-1, 13);
        set_sco(15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset row", 32'(row), 32'h0);
        check("midreset col", 32'(col), 32'h0);
        check("midreset pass_done", 32'(pass_done), 32'h0);
        rst_n = 1'b1;
        wait_state(1, 0);
        check("reload col", 32'(col), 32'hEE);

        // Randomised run: score changes, enable drops and occasional resets.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if ($urandom_range(0, 99) == 0)
                set_sco(15'($urandom), 15'($urandom), 15'($urandom), 15'($urandom));
            if (hold > 0) begin
                hold--;
                if (hold == 0) en = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                en = 1'b0;
                hold = int'($urandom_range(1, 60));
            end
            if ($urandom_range(0, 1499) == 0) rst_n = 1'b0;
        end
        rst_n = 1'b1; en = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
